// File: rtl/uart_pkg.sv
// UART shared definitions: FSM state encoding, oversampling and frame constants.
// Used by the receiver, baud generator and host-side interface.
`timescale 1ns/1ps
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;
    localparam int DATA_BITS  = 8;
    localparam int ACC_W      = 29;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BRK    = 3'd5
    } uart_state_e;
endpackage

// File: rtl/uart_rx_if.sv
// Host-side receive bus: held byte, ready/read handshake and sticky error flags.
// master = receiver side, slave = host/register block side.
`timescale 1ns/1ps
interface uart_rx_if;
    import uart_pkg::*;

    logic                 uart_rd_i;
    logic [DATA_BITS-1:0] uart_dat_o;
    logic                 uart_ready_o;
    logic                 uart_busy_o;
    logic                 uart_frame_err_o;
    logic                 uart_overrun_o;
    logic                 uart_parity_err_o;

    modport master (
        input  uart_rd_i,
        output uart_dat_o, uart_ready_o, uart_busy_o,
        output uart_frame_err_o, uart_overrun_o, uart_parity_err_o
    );

    modport slave (
        output uart_rd_i,
        input  uart_dat_o, uart_ready_o, uart_busy_o,
        input  uart_frame_err_o, uart_overrun_o, uart_parity_err_o
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Phase-accumulator oversample tick generator, mean rate OVERSAMPLE*BAUD; free-running.
// Latency: tick registered one cycle after the accumulator wraps; no backpressure.
`timescale 1ns/1ps
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD       = 9600,
    parameter int CLK        = 50000000,
    parameter int OVERSAMPLE = 16
) (
    input  logic sys_clk_i,
    input  logic sys_rst_n_i,
    output logic tick
);
    localparam logic [ACC_W-1:0] INC   = ACC_W'(OVERSAMPLE * BAUD);
    localparam logic [ACC_W-1:0] CLK_V = ACC_W'(CLK);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    // acc stays below CLK, so acc+INC < 2*CLK fits ACC_W without overflow
    assign sum  = acc + INC;
    assign wrap = (sum >= CLK_V);

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            acc  <= wrap ? (sum - CLK_V) : sum;
            tick <= wrap;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined), 16x oversampled, mid-bit sampling.
// Latency: ready one cycle after the mid-stop-bit sample; no backpressure, unread byte is overwritten (overrun).
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_RATE    = 9600,
    parameter int SYS_CLK_RATE = 50000000
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_n_i,
    input  logic       uart_rx_i,
    uart_rx_if.master  host
);
    logic                 tick;
    logic                 rx_meta;
    logic                 rxs;
    uart_state_e          state, state_nxt;
    logic [3:0]           tcnt, tcnt_nxt;
    logic [2:0]           bidx, bidx_nxt;
    logic [DATA_BITS-1:0] shifter, shift_nxt;
    logic                 done, done_nxt;
    logic                 ferr_set;
    logic [DATA_BITS-1:0] dat_q;
    logic                 ready_q;
    logic                 ferr_q;
    logic                 ovr_q;

    uart_baud_gen #(
        .BAUD       (BAUD_RATE),
        .CLK        (SYS_CLK_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_baud (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .tick        (tick)
    );

    // line is asynchronous; synchronizer resets to idle-high
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state   <= IDLE;
            tcnt    <= '0;
            bidx    <= '0;
            shifter <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tcnt    <= tcnt_nxt;
            bidx    <= bidx_nxt;
            shifter <= shift_nxt;
            done    <= done_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic perr_set;
    logic perr_q;
`endif

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        bidx_nxt  = bidx;
        shift_nxt = shifter;
        done_nxt  = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_set  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    state_nxt = START;
                    tcnt_nxt  = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt == 4'(MID_SAMPLE)) begin
                        if (rxs) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            tcnt_nxt  = '0;
                            bidx_nxt  = '0;
                        end
                    end else begin
                        tcnt_nxt = tcnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tcnt_nxt = tcnt + 4'd1;
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        shift_nxt = {rxs, shifter[DATA_BITS-1:1]};
                        if (bidx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end else begin
                            bidx_nxt = bidx + 3'd1;
                        end
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    tcnt_nxt = tcnt + 4'd1;
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        perr_set  = ^{shifter, rxs};
                        state_nxt = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    tcnt_nxt = tcnt + 4'd1;
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        if (rxs) begin
                            done_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_set  = 1'b1;
                            state_nxt = BRK;
                        end
                    end
                end
            end
            BRK: begin
                // a held-low line must go high before a new start is accepted
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // read clears first; same-cycle completion/errors then take priority
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            dat_q   <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (host.uart_rd_i) begin
                ready_q <= 1'b0;
                ferr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end
            if (ferr_set) ferr_q <= 1'b1;
            if (done) begin
                dat_q   <= shifter;
                ready_q <= 1'b1;
                if (ready_q && !host.uart_rd_i) ovr_q <= 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            perr_q <= 1'b0;
        end else begin
            if (host.uart_rd_i) perr_q <= 1'b0;
            if (perr_set)       perr_q <= 1'b1;
        end
    end
    assign host.uart_parity_err_o = perr_q;
`else
    assign host.uart_parity_err_o = 1'b0;
`endif

    assign host.uart_dat_o       = dat_q;
    assign host.uart_ready_o     = ready_q;
    assign host.uart_busy_o      = (state != IDLE);
    assign host.uart_frame_err_o = ferr_q;
    assign host.uart_overrun_o   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1 Mbaud / 50 MHz (50 clk per bit) with a byte scoreboard.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BIT = 50;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_MIN = 520;
    localparam int LAT_MAX = 540;
    logic bad_par = 1'b0;
`else
    localparam int LAT_MIN = 470;
    localparam int LAT_MAX = 490;
`endif

    logic sys_clk_i   = 1'b0;
    logic sys_rst_n_i = 1'b0;
    logic uart_rx_i   = 1'b1;

    uart_rx_if bus ();

    uart_rx #(
        .BAUD_RATE    (1000000),
        .SYS_CLK_RATE (50000000)
    ) dut (
        .sys_clk_i   (sys_clk_i),
        .sys_rst_n_i (sys_rst_n_i),
        .uart_rx_i   (uart_rx_i),
        .host        (bus)
    );

    always #10 sys_clk_i = ~sys_clk_i;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge sys_clk_i);
    endtask

    // leaves the line at the stop-bit level
    task automatic send_frame(input logic [7:0] d, input logic stop);
        uart_rx_i = 1'b0;
        cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = d[i];
            cycles(BIT);
        end
`ifdef UART_RX_PARITY_EN
        uart_rx_i = (^d) ^ bad_par;
        cycles(BIT);
`endif
        uart_rx_i = stop;
        cycles(BIT);
    endtask

    task automatic wait_ready(input int budget, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < budget) begin
            cycles(1);
            lat++;
            if (bus.uart_ready_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send_and_wait(input logic [7:0] d, output int lat, output bit ok);
        exp_q.push_back(d);
        fork
            send_frame(d, 1'b1);
            wait_ready(700, lat, ok);
        join
    endtask

    task automatic rd_pulse();
        bus.uart_rd_i = 1'b1;
        cycles(1);
        bus.uart_rd_i = 1'b0;
        cycles(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        bit         ok;
        logic [7:0] e;

        bus.uart_rd_i = 1'b0;
        cycles(4);
        chk("rst_dat",   32'(bus.uart_dat_o),        32'h0);
        chk("rst_ready", 32'(bus.uart_ready_o),      32'h0);
        chk("rst_busy",  32'(bus.uart_busy_o),       32'h0);
        chk("rst_ferr",  32'(bus.uart_frame_err_o),  32'h0);
        chk("rst_ovr",   32'(bus.uart_overrun_o),    32'h0);
        chk("rst_perr",  32'(bus.uart_parity_err_o), 32'h0);
        sys_rst_n_i = 1'b1;
        cycles(20);

        // single byte, latency and flags
        send_and_wait(8'hA5, lat, ok);
        chk("a5_ready_seen", 32'(ok), 32'h1);
        chk("a5_latency_in_window", 32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'h1);
        e = exp_q.pop_front();
        chk("a5_dat",  32'(bus.uart_dat_o),        32'(e));
        chk("a5_ferr", 32'(bus.uart_frame_err_o),  32'h0);
        chk("a5_ovr",  32'(bus.uart_overrun_o),    32'h0);
        chk("a5_perr", 32'(bus.uart_parity_err_o), 32'h0);
        rd_pulse();
        chk("a5_rd_ready", 32'(bus.uart_ready_o), 32'h0);
        chk("a5_rd_dat_kept", 32'(bus.uart_dat_o), 32'hA5);
        cycles(30);

        // back-to-back without read: overrun, newest byte held
        send_and_wait(8'h3C, lat, ok);
        chk("3c_ready_seen", 32'(ok), 32'h1);
        e = exp_q.pop_front();
        chk("3c_dat", 32'(bus.uart_dat_o), 32'(e));
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        cycles(10);
        e = exp_q.pop_front();
        chk("c3_dat",   32'(bus.uart_dat_o),     32'(e));
        chk("c3_ready", 32'(bus.uart_ready_o),   32'h1);
        chk("c3_ovr",   32'(bus.uart_overrun_o), 32'h1);
        rd_pulse();
        chk("c3_rd_ready", 32'(bus.uart_ready_o),   32'h0);
        chk("c3_rd_ovr",   32'(bus.uart_overrun_o), 32'h0);
        cycles(30);

        // 20-clock glitch is rejected
        uart_rx_i = 1'b0;
        cycles(5);
        chk("glitch_busy_high", 32'(bus.uart_busy_o), 32'h1);
        cycles(15);
        uart_rx_i = 1'b1;
        cycles(15);
        chk("glitch_busy_low", 32'(bus.uart_busy_o),  32'h0);
        cycles(600);
        chk("glitch_no_ready", 32'(bus.uart_ready_o), 32'h0);

        // bad stop bit followed by a break
        send_frame(8'h55, 1'b0);
        cycles(300);
        chk("brk_ferr",  32'(bus.uart_frame_err_o), 32'h1);
        chk("brk_ready", 32'(bus.uart_ready_o),     32'h0);
        chk("brk_busy",  32'(bus.uart_busy_o),      32'h1);
        uart_rx_i = 1'b1;
        cycles(10);
        chk("brk_release_busy",  32'(bus.uart_busy_o),  32'h0);
        chk("brk_release_ready", 32'(bus.uart_ready_o), 32'h0);
        rd_pulse();
        chk("brk_rd_ferr", 32'(bus.uart_frame_err_o), 32'h0);
        cycles(30);

        // asynchronous reset mid-byte, then recovery
        send_and_wait(8'h11, lat, ok);
        e = exp_q.pop_front();
        chk("11_dat", 32'(bus.uart_dat_o), 32'(e));
        cycles(30);
        uart_rx_i = 1'b0;
        cycles(150);
        chk("pre_rst_busy", 32'(bus.uart_busy_o), 32'h1);
        #3 sys_rst_n_i = 1'b0;
        #1;
        chk("arst_dat",   32'(bus.uart_dat_o),       32'h0);
        chk("arst_ready", 32'(bus.uart_ready_o),     32'h0);
        chk("arst_busy",  32'(bus.uart_busy_o),      32'h0);
        chk("arst_ferr",  32'(bus.uart_frame_err_o), 32'h0);
        uart_rx_i = 1'b1;
        cycles(3);
        sys_rst_n_i = 1'b1;
        cycles(50);
        send_and_wait(8'h81, lat, ok);
        chk("81_ready_seen", 32'(ok), 32'h1);
        e = exp_q.pop_front();
        chk("81_dat",  32'(bus.uart_dat_o),       32'(e));
        chk("81_ferr", 32'(bus.uart_frame_err_o), 32'h0);
        chk("81_ovr",  32'(bus.uart_overrun_o),   32'h0);
        rd_pulse();
        cycles(30);

`ifdef UART_RX_PARITY_EN
        bad_par = 1'b1;
        send_and_wait(8'h07, lat, ok);
        e = exp_q.pop_front();
        chk("par0_dat",  32'(bus.uart_dat_o),        32'(e));
        chk("par0_perr", 32'(bus.uart_parity_err_o), 32'h1);
        rd_pulse();
        chk("par0_rd_perr", 32'(bus.uart_parity_err_o), 32'h0);
        cycles(30);
        bad_par = 1'b0;
        send_and_wait(8'h07, lat, ok);
        e = exp_q.pop_front();
        chk("par1_dat",  32'(bus.uart_dat_o),        32'(e));
        chk("par1_perr", 32'(bus.uart_parity_err_o), 32'h0);
        rd_pulse();
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
